// File: rtl/timer_rr_scheduler.sv
// timer_rr_scheduler
// Shares one WIDTH-bit up-counter among NREQ requesters using round-robin
// arbitration. The winner holds a one-hot grant while the counter runs from
// 0 to its latched terminal count, then gets a one-cycle done pulse. If the
// winner drops its request mid-run, the scheduler returns to idle and pulses
// aborted instead.
module timer_rr_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_len,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic [WIDTH-1:0]      count,
    output logic [NREQ-1:0]       done,
    output logic                  aborted
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_reg,   state_next;
    logic [PTR_W-1:0]  ptr_reg,     ptr_next;
    logic [PTR_W-1:0]  winner_reg,  winner_next;
    logic [WIDTH-1:0]  len_reg,     len_next;
    logic [WIDTH-1:0]  count_reg,   count_next;
    logic [NREQ-1:0]   grant_reg,   grant_next;
    logic              busy_reg,    busy_next;
    logic [NREQ-1:0]   done_reg,    done_next;
    logic              aborted_reg, aborted_next;

    // Per-requester terminal counts unpacked from the flat input bus
    logic [WIDTH-1:0]  len_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_len
            assign len_arr[gi] = req_len[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Rotating-priority scan: first requester at or after ptr (mod NREQ)
    logic [PTR_W-1:0]  scan_win;
    logic              scan_hit;
    int                scan_idx;

    // Pick the round-robin winner among the currently asserted requests
    always_comb begin
        scan_win = '0;
        scan_hit = 1'b0;
        scan_idx = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = int'(ptr_reg) + k;
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            if (!scan_hit && req[scan_idx]) begin
                scan_hit = 1'b1;
                scan_win = PTR_W'(scan_idx);
            end
        end
    end

    // Pointer value that gives the requester after the current winner first pick
    logic [PTR_W-1:0]  ptr_after_winner;
    assign ptr_after_winner = (winner_reg == PTR_W'(NREQ - 1)) ? '0
                                                               : winner_reg + PTR_W'(1);

    // Next-state and registered-output logic for the IDLE/RUN/DONE sequence
    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        winner_next  = winner_reg;
        len_next     = len_reg;
        count_next   = count_reg;
        grant_next   = grant_reg;
        busy_next    = busy_reg;
        done_next    = '0;
        aborted_next = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                grant_next = '0;
                busy_next  = 1'b0;
                if (scan_hit) begin
                    // Terminal count is captured here so later req_len edits are ignored
                    winner_next = scan_win;
                    len_next    = len_arr[scan_win];
                    grant_next  = {{(NREQ-1){1'b0}}, 1'b1} << scan_win;
                    busy_next   = 1'b1;
                    count_next  = '0;
                    state_next  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!req[winner_reg]) begin
                    // Abort takes precedence over reaching the terminal count
                    state_next   = ST_IDLE;
                    grant_next   = '0;
                    busy_next    = 1'b0;
                    aborted_next = 1'b1;
                    ptr_next     = ptr_after_winner;
                end else if (count_reg == len_reg) begin
                    state_next = ST_DONE;
                    done_next  = grant_reg;
                end else begin
                    count_next = count_reg + WIDTH'(1);
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
                grant_next = '0;
                busy_next  = 1'b0;
                ptr_next   = ptr_after_winner;
            end
            default: begin
                state_next = ST_IDLE;
                grant_next = '0;
                busy_next  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset overrides everything, including mid-run
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            ptr_reg     <= '0;
            winner_reg  <= '0;
            len_reg     <= '0;
            count_reg   <= '0;
            grant_reg   <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= '0;
            aborted_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            winner_reg  <= winner_next;
            len_reg     <= len_next;
            count_reg   <= count_next;
            grant_reg   <= grant_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            aborted_reg <= aborted_next;
        end
    end

    assign grant   = grant_reg;
    assign busy    = busy_reg;
    assign count   = count_reg;
    assign done    = done_reg;
    assign aborted = aborted_reg;

endmodule

// File: tb/tb_timer_rr_scheduler.sv
// Directed testbench for timer_rr_scheduler (NREQ=4, WIDTH=8).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_timer_rr_scheduler;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_len;
    logic [NREQ-1:0]       grant;
    logic                  busy;
    logic [WIDTH-1:0]      count;
    logic [NREQ-1:0]       done;
    logic                  aborted;

    int vec_cnt;
    int err_cnt;

    timer_rr_scheduler #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .req_len (req_len),
        .grant   (grant),
        .busy    (busy),
        .count   (count),
        .done    (done),
        .aborted (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance one clock and settle just past the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_len(input int idx, input logic [WIDTH-1:0] v);
        req_len[idx*WIDTH +: WIDTH] = v;
    endtask

    // Full output snapshot: {grant, busy, count, done, aborted}
    function automatic logic [31:0] outs();
        return {14'd0, grant, busy, count, done, aborted};
    endfunction

    function automatic logic [31:0] mk(input logic [3:0] g, input logic b,
                                       input logic [7:0] c, input logic [3:0] d,
                                       input logic a);
        return {14'd0, g, b, c, d, a};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    int gcycles;
    int last_cnt;
    logic seen_done;
    logic seen_grant;
    logic wrap_seen;
    logic [7:0] done_cnt;

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        rst     = 1'b0;
        req     = '0;
        req_len = '0;

        // Reset state
        do_reset();
        check_val("reset_outs", outs(), mk(4'b0000, 1'b0, 8'd0, 4'b0000, 1'b0));

        // Test 1: single requester, len=3; len edit after arbitration is ignored
        req = 4'b0001;
        set_len(0, 8'd3);
        step();
        check_val("t1_c1", outs(), mk(4'b0001, 1'b1, 8'd0, 4'b0000, 1'b0));
        set_len(0, 8'd0);
        step();
        check_val("t1_c2", outs(), mk(4'b0001, 1'b1, 8'd1, 4'b0000, 1'b0));
        step();
        check_val("t1_c3", outs(), mk(4'b0001, 1'b1, 8'd2, 4'b0000, 1'b0));
        step();
        check_val("t1_c4", outs(), mk(4'b0001, 1'b1, 8'd3, 4'b0000, 1'b0));
        step();
        check_val("t1_c5_done", outs(), mk(4'b0001, 1'b1, 8'd3, 4'b0001, 1'b0));
        req = 4'b0000;
        step();
        check_val("t1_c6_idle", outs(), mk(4'b0000, 1'b0, 8'd3, 4'b0000, 1'b0));

        // Test 2: all request, len=1 each, ptr starts at 0 after reset
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < NREQ; i++) set_len(i, 8'd1);
        for (int g = 0; g < 5; g++) begin
            step();
            check_val($sformatf("t2_g%0d_run0", g), outs(),
                      mk(4'b0001 << (g % 4), 1'b1, 8'd0, 4'b0000, 1'b0));
            step();
            check_val($sformatf("t2_g%0d_run1", g), outs(),
                      mk(4'b0001 << (g % 4), 1'b1, 8'd1, 4'b0000, 1'b0));
            step();
            check_val($sformatf("t2_g%0d_done", g), outs(),
                      mk(4'b0001 << (g % 4), 1'b1, 8'd1, 4'b0001 << (g % 4), 1'b0));
            step();
            check_val($sformatf("t2_g%0d_idle", g), outs(),
                      mk(4'b0000, 1'b0, 8'd1, 4'b0000, 1'b0));
        end
        req = 4'b0000;

        // Test 3: len=0 gives one RUN cycle then DONE (ptr is now 1)
        set_len(2, 8'd0);
        req = 4'b0100;
        step();
        check_val("t3_run", outs(), mk(4'b0100, 1'b1, 8'd0, 4'b0000, 1'b0));
        step();
        check_val("t3_done", outs(), mk(4'b0100, 1'b1, 8'd0, 4'b0100, 1'b0));
        req = 4'b0000;
        step();
        check_val("t3_idle", outs(), mk(4'b0000, 1'b0, 8'd0, 4'b0000, 1'b0));

        // Test 4: abort; ptr=3 so scan 3,0,1 picks 1 over pending 2
        set_len(1, 8'd9);
        set_len(2, 8'd0);
        req = 4'b0110;
        step();
        check_val("t4_c0", outs(), mk(4'b0010, 1'b1, 8'd0, 4'b0000, 1'b0));
        step();
        step();
        check_val("t4_c2", outs(), mk(4'b0010, 1'b1, 8'd2, 4'b0000, 1'b0));
        req = 4'b0100;
        step();
        check_val("t4_abort", outs(), mk(4'b0000, 1'b0, 8'd2, 4'b0000, 1'b1));
        step();
        check_val("t4_next_grant", outs(), mk(4'b0100, 1'b1, 8'd0, 4'b0000, 1'b0));
        step();
        check_val("t4_next_done", outs(), mk(4'b0100, 1'b1, 8'd0, 4'b0100, 1'b0));
        req = 4'b0000;
        step();

        // Test 5: reset mid-run (ptr=3, so requester 1 wins, len=10)
        set_len(1, 8'd10);
        set_len(0, 8'd0);
        req = 4'b0010;
        for (int i = 0; i < 5; i++) step();
        check_val("t5_pre_rst", outs(), mk(4'b0010, 1'b1, 8'd4, 4'b0000, 1'b0));
        rst = 1'b1;
        req = 4'b1001;
        step();
        check_val("t5_rst", outs(), mk(4'b0000, 1'b0, 8'd0, 4'b0000, 1'b0));
        rst = 1'b0;
        step();
        check_val("t5_first_win", outs(), mk(4'b0001, 1'b1, 8'd0, 4'b0000, 1'b0));
        step();
        check_val("t5_done", outs(), mk(4'b0001, 1'b1, 8'd0, 4'b0001, 1'b0));
        req = 4'b0000;
        step();
        check_val("t5_idle", outs(), mk(4'b0000, 1'b0, 8'd0, 4'b0000, 1'b0));

        // Test 6: len=255 runs to 8'hFF without wrapping, grant lasts 257 cycles
        set_len(0, 8'hFF);
        req = 4'b0001;
        gcycles    = 0;
        last_cnt   = 0;
        seen_done  = 1'b0;
        seen_grant = 1'b0;
        wrap_seen  = 1'b0;
        done_cnt   = 8'd0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (grant != 4'b0000) begin
                seen_grant = 1'b1;
                gcycles++;
                if (int'(count) < last_cnt) wrap_seen = 1'b1;
                last_cnt = int'(count);
            end else if (seen_grant) begin
                break;
            end
            if (done != 4'b0000) begin
                seen_done = 1'b1;
                done_cnt  = count;
                req       = 4'b0000;
            end
        end
        check_val("t6_done_seen", {31'd0, seen_done}, 32'd1);
        check_val("t6_count_at_done", {24'd0, done_cnt}, 32'hFF);
        check_val("t6_no_wrap", {31'd0, wrap_seen}, 32'd0);
        check_val("t6_grant_len", gcycles, 32'd257);
        check_val("t6_idle", outs(), mk(4'b0000, 1'b0, 8'hFF, 4'b0000, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
